// File: rtl/trs80_pkg.sv
// Shared TRS-80 download types: arbiter state, buffered write request
// and the ioctl file index that carries the cassette image.
package trs80_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } arb_state_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_req_t;

    localparam logic [7:0] CAS_INDEX = 8'd1;

endpackage

// File: rtl/dn_write_arbiter_if.sv
// Download write bus: loader and ioctl requesters in, RAM write port out.
// master = requester/CPU side, slave = arbiter side.
interface dn_write_arbiter_if;
    logic        ldr_go;
    logic        ldr_wr;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_wait;
    logic        io_go;
    logic [7:0]  io_index;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [7:0]  io_data;
    logic        io_wait;
    logic        cpu_busy;
    logic        dn_go;
    logic        dn_wr;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data;
    logic        ovf;

    modport master (
        output ldr_go, ldr_wr, ldr_addr, ldr_data,
        output io_go, io_index, io_wr, io_addr, io_data,
        output cpu_busy,
        input  ldr_wait, io_wait,
        input  dn_go, dn_wr, dn_addr, dn_data, ovf
    );

    modport slave (
        input  ldr_go, ldr_wr, ldr_addr, ldr_data,
        input  io_go, io_index, io_wr, io_addr, io_data,
        input  cpu_busy,
        output ldr_wait, io_wait,
        output dn_go, dn_wr, dn_addr, dn_data, ovf
    );
endinterface

// File: rtl/wr_hold_reg.sv
// One-entry write holding register: wr_i captures req_i when empty (or
// being freed), free_i empties it; a strobe into a full entry sets ovf_o.
module wr_hold_reg
    import trs80_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    wr_i,
    input  wr_req_t req_i,
    input  logic    free_i,
    output logic    full_o,
    output wr_req_t req_o,
    output logic    ovf_o
);

    logic    full_q, full_d;
    logic    ovf_q, ovf_d;
    wr_req_t req_q, req_d;
    logic    room;
    logic    cap;

    // An entry leaving this cycle frees room for a same-cycle capture.
    always_comb begin
        room   = !full_q || free_i;
        cap    = wr_i && room;
        full_d = cap || (full_q && !free_i);
        req_d  = cap ? req_i : req_q;
        ovf_d  = ovf_q || (wr_i && !room);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
            req_q  <= req_d;
        end
    end

    assign full_o = full_q;
    assign req_o  = req_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/dn_write_arbiter.sv
// Shares the TRS-80 RAM download port between the CMD loader and the
// ioctl stream; writes are issued only while the CPU leaves RAM free.
// Ports: clk_sys, reset_n (async, active low), bus (slave modport).
module dn_write_arbiter
    import trs80_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int WR_HOLD    = 2
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    dn_write_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_t    state_q, state_d;
    logic          gnt_io_q, gnt_io_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [2:0]    hold_q, hold_d;
    wr_req_t       out_q, out_d;
    logic          go_q, go_d;

    logic    ldr_full, io_full;
    logic    ldr_ovf, io_ovf;
    wr_req_t ldr_req, io_req;
    wr_req_t ldr_in, io_in;
    logic    io_wr_ok;
    logic    free_ldr, free_io;
    logic    pick_io;
    logic    strobe;

    assign ldr_in   = '{addr: {8'h00, bus.ldr_addr}, data: bus.ldr_data};
    assign io_in    = '{addr: {7'b0, |bus.io_index, bus.io_addr},
                        data: bus.io_data};
    assign io_wr_ok = bus.io_wr && bus.io_go;

    wr_hold_reg u_ldr (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .wr_i   (bus.ldr_wr),
        .req_i  (ldr_in),
        .free_i (free_ldr),
        .full_o (ldr_full),
        .req_o  (ldr_req),
        .ovf_o  (ldr_ovf)
    );

    wr_hold_reg u_io (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .wr_i   (io_wr_ok),
        .req_i  (io_in),
        .free_i (free_io),
        .full_o (io_full),
        .req_o  (io_req),
        .ovf_o  (io_ovf)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (ldr_full || io_full) state_d = SETUP;
            SETUP:  if (!bus.cpu_busy) state_d = STROBE;
            STROBE: state_d = (WR_HOLD == 0) ? IDLE : HOLD;
            HOLD:   if (hold_q == 3'(WR_HOLD - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loader wins unless io has already waited out STARVE_LIM grants.
    always_comb begin
        strobe   = (state_q == STROBE);
        pick_io  = io_full &&
                   (!ldr_full || starve_q == SW'(STARVE_LIM));
        free_ldr = strobe && !gnt_io_q;
        free_io  = strobe && gnt_io_q;
        bus.dn_wr    = strobe;
        bus.dn_addr  = out_q.addr;
        bus.dn_data  = out_q.data;
        bus.dn_go    = go_q;
        bus.ldr_wait = ldr_full;
        bus.io_wait  = io_full;
        bus.ovf      = ldr_ovf || io_ovf;
    end

    always_comb begin
        gnt_io_d = gnt_io_q;
        out_d    = out_q;
        starve_d = starve_q;
        hold_d   = hold_q;
        if (state_q == IDLE && (ldr_full || io_full)) begin
            gnt_io_d = pick_io;
            out_d    = pick_io ? io_req : ldr_req;
            if (pick_io) begin
                starve_d = '0;
            end else if (io_full) begin
                starve_d = starve_q + SW'(1);
            end
        end
        if (!io_full) starve_d = '0;
        if (state_q == STROBE) begin
            hold_d = '0;
        end else if (state_q == HOLD) begin
            hold_d = hold_q + 3'd1;
        end
        go_d = bus.ldr_go || ldr_full || io_full ||
               (bus.io_go && bus.io_index == CAS_INDEX);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            gnt_io_q <= 1'b0;
            out_q    <= '0;
            starve_q <= '0;
            hold_q   <= '0;
            go_q     <= 1'b0;
        end else begin
            gnt_io_q <= gnt_io_d;
            out_q    <= out_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
            go_q     <= go_d;
        end
    end

endmodule

// File: tb/tb_dn_write_arbiter.sv
// Bench for dn_write_arbiter: directed scenarios followed by random
// traffic checked against per-requester queues of accepted writes.
module tb_dn_write_arbiter;
    import trs80_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wr = -100;
    logic [31:0] lq[$];
    logic [31:0] iq[$];

    always #5 clk = ~clk;

    dn_write_arbiter_if bus();

    dn_write_arbiter #(
        .STARVE_LIM (4),
        .WR_HOLD    (2)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        while (bus.dn_wr !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.dn_wr), 32'd1);
    endtask

    // Every issued write must be the oldest accepted write of one source.
    task automatic mon();
        logic [31:0] got;
        logic        hit;
        if (bus.dn_wr === 1'b1) begin
            got = {bus.dn_addr, bus.dn_data};
            hit = 1'b0;
            if (lq.size() > 0 && got == lq[0]) begin
                void'(lq.pop_front());
                hit = 1'b1;
            end else if (iq.size() > 0 && got == iq[0]) begin
                void'(iq.pop_front());
                hit = 1'b1;
            end
            chk("rand_wr", 32'(hit), 32'd1);
            chk("rand_gap", 32'((cyc - last_wr) >= 5), 32'd1);
            last_wr = cyc;
        end
    endtask

    initial begin
        int nl;
        int nw;
        logic io_seen;
        logic [7:0]  idx;
        logic [15:0] a;
        logic [7:0]  d;

        bus.ldr_go = 0; bus.ldr_wr = 0; bus.ldr_addr = 0; bus.ldr_data = 0;
        bus.io_go = 0; bus.io_index = 0; bus.io_wr = 0;
        bus.io_addr = 0; bus.io_data = 0; bus.cpu_busy = 0;

        repeat (2) step();
        chk("rst_go", 32'(bus.dn_go), 0);
        chk("rst_wr", 32'(bus.dn_wr), 0);
        chk("rst_addr", 32'(bus.dn_addr), 0);
        chk("rst_data", 32'(bus.dn_data), 0);
        chk("rst_lwait", 32'(bus.ldr_wait), 0);
        chk("rst_iwait", 32'(bus.io_wait), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single loader write, cycle-exact
        bus.ldr_wr = 1; bus.ldr_addr = 16'h4000; bus.ldr_data = 8'hA5;
        step();
        bus.ldr_wr = 0;
        chk("t1_wait_up", 32'(bus.ldr_wait), 1);
        chk("t1_nowr0", 32'(bus.dn_wr), 0);
        step();
        chk("t1_nowr1", 32'(bus.dn_wr), 0);
        chk("t1_addr_setup", 32'(bus.dn_addr), 32'h004000);
        step();
        chk("t1_wr", 32'(bus.dn_wr), 1);
        chk("t1_addr", 32'(bus.dn_addr), 32'h004000);
        chk("t1_data", 32'(bus.dn_data), 32'hA5);
        step();
        chk("t1_wr_1cyc", 32'(bus.dn_wr), 0);
        chk("t1_wait_dn", 32'(bus.ldr_wait), 0);
        chk("t1_ovf", 32'(bus.ovf), 0);
        repeat (4) step();

        // cassette mapping, io_index = 1
        bus.io_go = 1; bus.io_index = 8'd1;
        bus.io_wr = 1; bus.io_addr = 16'h0123; bus.io_data = 8'h55;
        step();
        bus.io_wr = 0;
        wait_wr("cas1_wr");
        chk("cas1_addr", 32'(bus.dn_addr), 32'h010123);
        chk("cas1_data", 32'(bus.dn_data), 32'h55);
        chk("cas1_go", 32'(bus.dn_go), 1);
        repeat (4) step();
        chk("cas1_go_idle", 32'(bus.dn_go), 1);

        // io_index = 0: no high bank, dn_go only while pending
        bus.io_index = 8'd0;
        bus.io_wr = 1;
        step();
        bus.io_wr = 0;
        wait_wr("cas0_wr");
        chk("cas0_addr", 32'(bus.dn_addr), 32'h000123);
        chk("cas0_go", 32'(bus.dn_go), 1);
        repeat (5) step();
        chk("cas0_go_idle", 32'(bus.dn_go), 0);
        bus.io_go = 0;

        // overflow: second strobe while full is dropped
        bus.ldr_wr = 1; bus.ldr_addr = 16'h2000; bus.ldr_data = 8'h11;
        step();
        bus.ldr_addr = 16'h2001; bus.ldr_data = 8'h22;
        step();
        bus.ldr_wr = 0;
        chk("ovf_set", 32'(bus.ovf), 1);
        wait_wr("ovf_wr");
        chk("ovf_addr", 32'(bus.dn_addr), 32'h002000);
        chk("ovf_data", 32'(bus.dn_data), 32'h11);
        repeat (4) step();
        chk("ovf_nobuf", 32'(bus.ldr_wait), 0);
        chk("ovf_sticky", 32'(bus.ovf), 1);

        // starvation: io wins after exactly 4 loader writes
        bus.io_go = 1; bus.io_index = 8'd1;
        bus.io_wr = 1; bus.io_addr = 16'h0777; bus.io_data = 8'h77;
        bus.ldr_wr = 1; bus.ldr_addr = 16'h3000; bus.ldr_data = 8'h00;
        nl = 0;
        io_seen = 0;
        for (int i = 0; i < 80 && !io_seen; i++) begin
            step();
            bus.io_wr = 0;
            bus.ldr_addr = bus.ldr_addr + 16'd1;
            if (bus.dn_wr === 1'b1) begin
                if (bus.dn_addr === 24'h010777) io_seen = 1;
                else nl++;
            end
        end
        chk("starve_io_seen", 32'(io_seen), 1);
        chk("starve_count", 32'(nl), 4);
        bus.ldr_wr = 0;
        bus.io_go = 0;
        repeat (12) step();

        // CPU stall in SETUP
        bus.cpu_busy = 1;
        bus.ldr_wr = 1; bus.ldr_addr = 16'h1234; bus.ldr_data = 8'h3C;
        step();
        bus.ldr_wr = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_nowr", 32'(bus.dn_wr), 0);
            chk("stall_hold", {bus.dn_addr, bus.dn_data}, 32'h0012343C);
        end
        bus.cpu_busy = 0;
        step();
        chk("stall_release", 32'(bus.dn_wr), 1);
        repeat (4) step();

        // drain after ldr_go falls
        bus.ldr_go = 1; bus.cpu_busy = 1;
        bus.ldr_wr = 1; bus.ldr_addr = 16'h5000; bus.ldr_data = 8'h99;
        step();
        bus.ldr_wr = 0;
        bus.ldr_go = 0;
        repeat (3) begin
            step();
            chk("drain_go", 32'(bus.dn_go), 1);
        end
        bus.cpu_busy = 0;
        wait_wr("drain_wr");
        chk("drain_go_wr", 32'(bus.dn_go), 1);
        repeat (3) step();
        chk("drain_go_end", 32'(bus.dn_go), 0);

        // async reset during STROBE
        bus.ldr_go = 1;
        bus.ldr_wr = 1; bus.ldr_addr = 16'h6000; bus.ldr_data = 8'hEE;
        step();
        bus.ldr_wr = 0;
        wait_wr("ar_wr");
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wr_drop", 32'(bus.dn_wr), 0);
        chk("ar_addr", 32'(bus.dn_addr), 0);
        chk("ar_data", 32'(bus.dn_data), 0);
        chk("ar_go", 32'(bus.dn_go), 0);
        chk("ar_lwait", 32'(bus.ldr_wait), 0);
        chk("ar_ovf", 32'(bus.ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        bus.ldr_go = 0;
        nw = 0;
        repeat (10) begin
            step();
            if (bus.dn_wr === 1'b1) nw++;
        end
        chk("ar_no_write", 32'(nw), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step();
            mon();
            bus.ldr_wr = 0;
            bus.io_wr = 0;
            bus.cpu_busy = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) bus.io_go = ~bus.io_go;
            if (!bus.ldr_wait && $urandom_range(2) == 0) begin
                a = 16'($urandom);
                d = 8'($urandom);
                bus.ldr_wr = 1; bus.ldr_addr = a; bus.ldr_data = d;
                lq.push_back({8'h00, a, d});
            end
            if ($urandom_range(2) == 0) begin
                a = 16'($urandom);
                d = 8'($urandom);
                idx = 8'($urandom_range(2));
                if (!bus.io_go) begin
                    bus.io_wr = 1; bus.io_addr = a; bus.io_data = d;
                    bus.io_index = idx;
                end else if (!bus.io_wait) begin
                    bus.io_wr = 1; bus.io_addr = a; bus.io_data = d;
                    bus.io_index = idx;
                    iq.push_back({7'b0, (idx != 0), a, d});
                end
            end
        end
        bus.ldr_wr = 0;
        bus.io_wr = 0;
        bus.cpu_busy = 0;
        repeat (40) begin
            step();
            mon();
        end
        chk("rand_ldr_left", 32'(lq.size()), 0);
        chk("rand_io_left", 32'(iq.size()), 0);
        chk("rand_ovf", 32'(bus.ovf), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
